// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: store mask-mode encodings and the memory-wait FSM state.
package pipe_pkg;
  localparam logic [2:0] MASK_B = 3'd0;
  localparam logic [2:0] MASK_H = 3'd1;
  localparam logic [2:0] MASK_W = 3'd2;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_e;

  function automatic logic is_subword(input logic [2:0] mode);
    return (mode == MASK_B) || (mode == MASK_H);
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle; master is the pipeline datapath, slave the controller.
interface hazard_ctrl_if #(parameter int REG_AW = 5);
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              id_rs1_used, id_rs2_used;
  logic              ex_valid, ex_memRead, ex_memWrite, ex_jump, ex_branch, ex_br_taken;
  logic              mem_memWrite;
  logic [2:0]        mem_maskMode;
  logic              mem_req, mem_ready;
  logic              pc_redirect;
  logic              if_id_stall, id_ex_stall, ex_mem_stall;
  logic              if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic              mem_wait;

  modport master (
    output id_rs1, id_rs2, ex_rd, id_rs1_used, id_rs2_used, ex_valid, ex_memRead, ex_memWrite,
           ex_jump, ex_branch, ex_br_taken, mem_memWrite, mem_maskMode, mem_req, mem_ready,
    input  pc_redirect, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_wait
  );
  modport slave (
    input  id_rs1, id_rs2, ex_rd, id_rs1_used, id_rs2_used, ex_valid, ex_memRead, ex_memWrite,
           ex_jump, ex_branch, ex_br_taken, mem_memWrite, mem_maskMode, mem_req, mem_ready,
    output pc_redirect, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_wait
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Load destination shift register (LOAD_LAT-1 deep) plus ID source match against EX and all entries.
module hazard_scoreboard
  import pipe_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              load_v,
  input  logic [REG_AW-1:0] load_rd,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic              hit
);
  localparam int DEPTH = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;

  function automatic logic uses(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] s1,
                                input logic [REG_AW-1:0] s2, input logic u1, input logic u2);
    return (rd != '0) && ((u1 && s1 == rd) || (u2 && s2 == rd));
  endfunction

  logic ex_hit;
  assign ex_hit = ex_load && uses(ex_rd, rs1, rs2, rs1_used, rs2_used);

  generate
    if (LOAD_LAT > 1) begin : g_sb
      logic [DEPTH-1:0]             v;
      logic [DEPTH-1:0][REG_AW-1:0] rd;
      logic [DEPTH-1:0]             m;

      // Holds while the pipe is frozen so in-flight loads keep their age.
      always_ff @(posedge clk) begin
        if (rst) begin
          v  <= '0;
          rd <= '0;
        end else if (shift_en) begin
          v[0]  <= load_v;
          rd[0] <= load_rd;
          for (int i = 1; i < DEPTH; i++) begin
            v[i]  <= v[i-1];
            rd[i] <= rd[i-1];
          end
        end
      end

      for (genvar i = 0; i < DEPTH; i++) begin : g_m
        assign m[i] = v[i] && uses(rd[i], rs1, rs2, rs1_used, rs2_used);
      end
      assign hit = ex_hit || (|m);
    end else begin : g_nosb
      logic unused_sb;
      assign unused_sb = ^{clk, rst, shift_en, load_v, load_rd};
      assign hit       = ex_hit;
    end
  endgenerate
endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage RV hazard/stall controller: memory-wait freeze, sub-word store RMW stall, redirect, load-use.
// Optional HAZARD_PERF_EN adds stall/flush/load-use event counters.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int LOAD_LAT  = 1,
  parameter int RMW_STALL = 1
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_ldu_cnt
`endif
);
  mem_state_e state;
  logic       rmw_q;
  logic       freeze, rmw_cond, rmw, redir, ldu, sb_hit, load_v;

  assign freeze   = bus.mem_req && !bus.mem_ready;
  assign rmw_cond = (RMW_STALL != 0) && bus.ex_valid && (bus.ex_memRead || bus.ex_memWrite) &&
                    bus.mem_memWrite && is_subword(bus.mem_maskMode);
  // rmw_q keeps a static store/access pair from re-stalling: one bubble per store.
  assign rmw      = rmw_cond && !rmw_q && !freeze;
  assign redir    = bus.ex_valid && (bus.ex_jump || (bus.ex_branch && bus.ex_br_taken)) &&
                    !freeze && !rmw;
  assign ldu      = sb_hit && !freeze && !rmw && !redir;
  assign load_v   = bus.ex_valid && bus.ex_memRead && (bus.ex_rd != '0) && !rmw;

  hazard_scoreboard #(.REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .shift_en (!freeze),
    .load_v   (load_v),
    .load_rd  (bus.ex_rd),
    .ex_load  (bus.ex_valid && bus.ex_memRead),
    .ex_rd    (bus.ex_rd),
    .rs1      (bus.id_rs1),
    .rs2      (bus.id_rs2),
    .rs1_used (bus.id_rs1_used),
    .rs2_used (bus.id_rs2_used),
    .hit      (sb_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rmw_q <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (freeze) state <= WAIT;
        WAIT:    if (bus.mem_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (!freeze) rmw_q <= rmw;
    end
  end

  always_comb begin
    bus.pc_redirect  = 1'b0;
    bus.if_id_stall  = 1'b0;
    bus.id_ex_stall  = 1'b0;
    bus.ex_mem_stall = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_flush = 1'b0;
    bus.mem_wb_flush = 1'b0;
    bus.mem_wait     = (state == WAIT) && !rst;
    if (!rst) begin
      if (freeze) begin
        bus.if_id_stall  = 1'b1;
        bus.id_ex_stall  = 1'b1;
        bus.ex_mem_stall = 1'b1;
        bus.mem_wb_flush = 1'b1;
      end else if (rmw) begin
        bus.if_id_stall  = 1'b1;
        bus.id_ex_stall  = 1'b1;
        bus.ex_mem_flush = 1'b1;
      end else if (redir) begin
        bus.pc_redirect  = 1'b1;
        bus.if_id_flush  = 1'b1;
        bus.id_ex_flush  = 1'b1;
      end else if (ldu) begin
        bus.if_id_stall  = 1'b1;
        bus.id_ex_flush  = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_ldu_cnt   <= '0;
    end else begin
      if (freeze || rmw) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redir)         perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (ldu)           perf_ldu_cnt   <= perf_ldu_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three configs (LAT1/RMW on, LAT3/RMW on, LAT1/RMW off) on shared stimulus.
module tb_hazard_ctrl;
  typedef struct packed {
    logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic exv; logic [4:0] exrd; logic rd, wr, jmp, br, tk;
    logic mw; logic [2:0] mm; logic req, rdy;
  } in_t;
  typedef struct { in_t in; logic [8:0] ea; logic [8:0] ec; } vec_t;

  // {redirect, s_ifid, s_idex, s_exmem, f_ifid, f_idex, f_exmem, f_memwb, wait}
  localparam logic [8:0] NONE  = 9'b000000000;
  localparam logic [8:0] LDU   = 9'b010001000;
  localparam logic [8:0] REDIR = 9'b100011000;
  localparam logic [8:0] RMW   = 9'b011000100;
  localparam logic [8:0] FRZ   = 9'b011100010;
  localparam logic [8:0] W     = 9'b000000001;

  logic       clk = 1'b0;
  logic       rst;
  in_t        cur;
  logic [8:0] outs [3];
  int         errors, checks;
`ifdef HAZARD_PERF_EN
  logic [31:0] p_stall [3];
  logic [31:0] p_flush [3];
  logic [31:0] p_ldu   [3];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hazard_ctrl_if #(.REG_AW(5)) bus ();
    assign bus.id_rs1 = cur.rs1;       assign bus.id_rs1_used  = cur.u1;
    assign bus.id_rs2 = cur.rs2;       assign bus.id_rs2_used  = cur.u2;
    assign bus.ex_valid = cur.exv;     assign bus.ex_rd        = cur.exrd;
    assign bus.ex_memRead = cur.rd;    assign bus.ex_memWrite  = cur.wr;
    assign bus.ex_jump = cur.jmp;      assign bus.ex_branch    = cur.br;
    assign bus.ex_br_taken = cur.tk;   assign bus.mem_memWrite = cur.mw;
    assign bus.mem_maskMode = cur.mm;  assign bus.mem_req      = cur.req;
    assign bus.mem_ready = cur.rdy;
    assign outs[g] = {bus.pc_redirect, bus.if_id_stall, bus.id_ex_stall, bus.ex_mem_stall,
                      bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.mem_wb_flush,
                      bus.mem_wait};
    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(g == 1 ? 3 : 1), .RMW_STALL(g == 2 ? 0 : 1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall_cnt (p_stall[g]),
      .perf_flush_cnt (p_flush[g]),
      .perf_ldu_cnt   (p_ldu[g])
`endif
    );
  end

  function automatic in_t mk(input int rs1, u1, rs2, u2, exv, exrd, rd, wr, jmp, br, tk,
                             mw, mm, req, rdy);
    in_t r;
    r.rs1 = 5'(rs1); r.u1 = 1'(u1); r.rs2 = 5'(rs2); r.u2 = 1'(u2);
    r.exv = 1'(exv); r.exrd = 5'(exrd); r.rd = 1'(rd); r.wr = 1'(wr);
    r.jmp = 1'(jmp); r.br = 1'(br); r.tk = 1'(tk); r.mw = 1'(mw);
    r.mm = 3'(mm); r.req = 1'(req); r.rdy = 1'(rdy);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  // Apply current inputs for one cycle and compare instance g mid-cycle.
  task automatic cyc(input string nm, input int g, input logic [8:0] e);
    @(negedge clk);
    chk(nm, 32'(outs[g]), 32'(e));
    adv();
  endtask

  task automatic pulse_rst();
    rst = 1'b1; cur = '0; adv(); rst = 1'b0;
  endtask

  vec_t tbl [25];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1);
  end

  initial begin
    errors = 0; checks = 0;
    //               rs1 u1 rs2 u2 exv rd ld st jmp br tk mw mm req rdy   A      C
    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0), NONE,  NONE};
    tbl[1]  = '{mk(5, 1, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 2, 0, 0), LDU,   LDU};
    tbl[2]  = '{mk(1, 1, 5, 1, 1, 5, 1, 0, 0, 0, 0, 0, 2, 0, 0), LDU,   LDU};
    tbl[3]  = '{mk(5, 0, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 2, 0, 0), NONE,  NONE};
    tbl[4]  = '{mk(0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0), NONE,  NONE};
    tbl[5]  = '{mk(5, 1, 1, 1, 0, 5, 1, 0, 0, 0, 0, 0, 2, 0, 0), NONE,  NONE};
    tbl[6]  = '{mk(5, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0), REDIR, REDIR};
    tbl[7]  = '{mk(5, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0), NONE,  NONE};
    tbl[8]  = '{mk(5, 1, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 2, 0, 0), REDIR, REDIR};
    tbl[9]  = '{mk(9, 1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0), RMW,   NONE};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0), NONE,  NONE};
    tbl[11] = '{mk(9, 1, 0, 0, 1, 3, 0, 1, 0, 0, 0, 1, 1, 0, 0), RMW,   NONE};
    tbl[12] = '{mk(9, 1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 1, 2, 0, 0), NONE,  NONE};
    tbl[13] = '{mk(3, 1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0), RMW,   LDU};
    tbl[14] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0), FRZ,   FRZ};
    tbl[15] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1), W,     W};
    tbl[16] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0), NONE,  NONE};
    tbl[17] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 1), NONE,  NONE};
    tbl[18] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0), NONE,  NONE};
    tbl[19] = '{mk(5, 1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 2, 1, 0), FRZ,   FRZ};
    tbl[20] = '{mk(5, 1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 2, 1, 1), LDU|W, LDU|W};
    tbl[21] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0), NONE,  NONE};
    tbl[22] = '{mk(9, 1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 1, 0, 1, 0), FRZ,   FRZ};
    tbl[23] = '{mk(9, 1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 1, 0, 1, 1), RMW|W, W};
    tbl[24] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0), NONE,  NONE};

    // Reset cycle with active hazards on the inputs: every output must be 0.
    pulse_rst();
    rst = 1'b1;
    cur = mk(5, 1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    @(negedge clk);
    for (int g = 0; g < 3; g++) chk($sformatf("rst_outs%0d", g), 32'(outs[g]), 32'(NONE));
`ifdef HAZARD_PERF_EN
    chk("rst_perf_stall", p_stall[0], 0);
    chk("rst_perf_flush", p_flush[0], 0);
    chk("rst_perf_ldu",   p_ldu[0],   0);
`endif
    adv();
    rst = 1'b0; cur = '0;

    for (int i = 0; i < 25; i++) begin
      cur = tbl[i].in;
      @(negedge clk);
      chk($sformatf("vec%0d_lat1", i),   32'(outs[0]), 32'(tbl[i].ea));
      chk($sformatf("vec%0d_normw", i), 32'(outs[2]), 32'(tbl[i].ec));
      adv();
    end

    // LOAD_LAT=3: lw x7 then dependent add stalls three cycles.
    pulse_rst();
    cur = mk(7, 1, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 2, 0, 0);
    cyc("lat3_c0", 1, LDU);
    cur.exv = 1'b0;
    cyc("lat3_c1", 1, LDU);
    cyc("lat3_c2", 1, LDU);
    @(negedge clk);
    chk("lat3_c3", 32'(outs[1]), 32'(NONE));
`ifdef HAZARD_PERF_EN
    chk("perf_ldu_lat3", p_ldu[1], 3);
`endif
    adv();

    // LOAD_LAT=3 unrelated source x9: no stall at all.
    pulse_rst();
    cur = mk(9, 1, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 2, 0, 0);
    cyc("lat3_unrel0", 1, NONE);
    cur.exv = 1'b0;
    for (int k = 1; k < 4; k++) cyc($sformatf("lat3_unrel%0d", k), 1, NONE);

    // Scoreboard holds through freeze, then drains.
    pulse_rst();
    cur = mk(10, 1, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 2, 0, 0);
    cyc("sbhold_c0", 1, NONE);
    cur = mk(7, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
    cyc("sbhold_frz0", 1, FRZ);
    cyc("sbhold_frz1", 1, FRZ | W);
    cur.rdy = 1'b1;
    cyc("sbhold_rel", 1, LDU | W);
    cur.req = 1'b0; cur.rdy = 1'b0;
    cyc("sbhold_sb1", 1, LDU);
    cyc("sbhold_done", 1, NONE);

    // jal in EX with a pending load-use from the scoreboard: redirect wins.
    pulse_rst();
    cur = mk(10, 1, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 2, 0, 0);
    cyc("jal_ldu_c0", 1, NONE);
    cur = mk(7, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 2, 0, 0);
    cyc("jal_ldu_c1", 1, REDIR);

    // Four-cycle memory wait with a taken branch held in EX.
    pulse_rst();
    cur = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 2, 1, 0);
    cyc("wait_c0", 0, FRZ);
    for (int k = 1; k < 4; k++) cyc($sformatf("wait_c%0d", k), 0, FRZ | W);
    cur.rdy = 1'b1;
    cyc("wait_release", 0, REDIR | W);
    cur = '0;
    @(negedge clk);
    chk("wait_after", 32'(outs[0]), 32'(NONE));
`ifdef HAZARD_PERF_EN
    chk("perf_stall_wait", p_stall[0], 4);
    chk("perf_flush_wait", p_flush[0], 1);
`endif
    adv();

    // Reset in the middle of WAIT: outputs 0, FSM back to IDLE.
    cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
    cyc("rstwait_c0", 0, FRZ);
    cyc("rstwait_c1", 0, FRZ | W);
    rst = 1'b1;
    cyc("rstwait_rst", 0, NONE);
    rst = 1'b0;
    cyc("rstwait_after", 0, FRZ);

    // Reset in the middle of a LOAD_LAT=3 load-use: scoreboard cleared.
    pulse_rst();
    cur = mk(7, 1, 0, 1, 1, 7, 1, 0, 0, 0, 0, 0, 2, 0, 0);
    cyc("rstldu_c0", 1, LDU);
    rst = 1'b1;
    cyc("rstldu_rst", 1, NONE);
    rst = 1'b0; cur.exv = 1'b0;
    cyc("rstldu_after", 1, NONE);

    // A static sub-word store / load pair produces a single RMW bubble.
    pulse_rst();
    cur = mk(9, 1, 0, 1, 1, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    cyc("rmw_once_c0", 0, RMW);
    cyc("rmw_once_c1", 0, NONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
